base_ram_ctrl: RTL and testbench

//  Responder end of the CPU memory bus. Serves the CPU instruction-fetch port (if_*) and

---
 rtl/base_ram_ctrl_pkg.sv | 20 ++
 rtl/base_ram_ctrl.sv | 165 ++++++++++++++++
 tb/tb_base_ram_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/base_ram_ctrl_pkg.sv
// Shared encodings for the base SRAM controller: FSM states, bus port codes and byte-enable constants.
package base_ram_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WSET = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic {
        BUS_PORT_IF  = 1'b0,
        BUS_PORT_MEM = 1'b1
    } bus_port_t;

    localparam logic [3:0] BE_N_NONE = 4'hF;
    localparam logic [3:0] BE_N_ALL  = 4'h0;

endpackage

// File: rtl/base_ram_ctrl.sv
// CPU-bus responder for the 32-bit asynchronous base SRAM: arbitrates the fetch and data ports,
// sequences multi-cycle read/write strobes, and returns one-cycle acks with captured read data.
module base_ram_ctrl
    import base_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_ce_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_ack_o,

    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              mem_ack_o,

    output logic              stall_o,

    input  logic [31:0]       ram_data_i,
    output logic [31:0]       ram_data_o,
    output logic              ram_data_oe,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_be_n_o,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o
);

    localparam int              CNT_W     = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t             r_state;
    bus_port_t          r_port;
    logic [CNT_W-1:0]   r_wait;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [3:0]         r_be_n;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic               r_data_oe;
    logic [31:0]        r_wdata;
    logic               r_if_ack;
    logic               r_mem_ack;
    logic [31:0]        r_if_data;
    logic [31:0]        r_mem_data;

    // Byte-offset bits and bits above the SRAM window alias away.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                                  mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_port     <= BUS_PORT_IF;
            r_wait     <= '0;
            r_ram_addr <= '0;
            r_be_n     <= BE_N_NONE;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_data_oe  <= 1'b0;
            r_wdata    <= '0;
            r_if_ack   <= 1'b0;
            r_mem_ack  <= 1'b0;
            r_if_data  <= '0;
            r_mem_data <= '0;
        end else begin
            // NOTE: acks default low every cycle so they can only ever be one-cycle pulses out of DONE.
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (mem_ce_i) begin
                        r_port     <= BUS_PORT_MEM;
                        r_ram_addr <= mem_addr_i[ADDR_W+1:2];
                        r_be_n     <= ~mem_sel_i;
                        r_ce_n     <= 1'b0;
                        if (mem_we_i) begin
                            r_wdata   <= mem_data_i;
                            r_data_oe <= 1'b1;
                            r_state   <= S_WSET;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_state <= S_RD;
                        end
                    end else if (if_ce_i) begin
                        r_port     <= BUS_PORT_IF;
                        r_ram_addr <= if_addr_i[ADDR_W+1:2];
                        r_be_n     <= BE_N_ALL;
                        r_ce_n     <= 1'b0;
                        r_oe_n     <= 1'b0;
                        r_state    <= S_RD;
                    end
                end
                S_RD: begin
                    if (r_wait == WAIT_LAST) begin
                        if (r_port == BUS_PORT_MEM) begin
                            r_mem_data <= ram_data_i;
                            r_mem_ack  <= 1'b1;
                        end else begin
                            r_if_data <= ram_data_i;
                            r_if_ack  <= 1'b1;
                        end
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_wait  <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                S_WSET: begin
                    r_we_n  <= 1'b0;
                    r_wait  <= '0;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (r_wait == WAIT_LAST) begin
                        // Data stays driven through DONE to give the SRAM hold time after we_n rises.
                        r_we_n    <= 1'b1;
                        r_ce_n    <= 1'b1;
                        r_mem_ack <= 1'b1;
                        r_wait    <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_data_oe <= 1'b0;
                    r_be_n    <= BE_N_NONE;
                    r_wait    <= '0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_data_o   = r_if_data;
    assign if_ack_o    = r_if_ack;
    assign mem_data_o  = r_mem_data;
    assign mem_ack_o   = r_mem_ack;
    assign stall_o     = (if_ce_i & ~r_if_ack) | (mem_ce_i & ~r_mem_ack);
    assign ram_data_o  = r_wdata;
    assign ram_data_oe = r_data_oe;
    assign ram_addr_o  = r_ram_addr;
    assign ram_be_n_o  = r_be_n;
    assign ram_ce_n_o  = r_ce_n;
    assign ram_oe_n_o  = r_oe_n;
    assign ram_we_n_o  = r_we_n;

endmodule

// File: tb/tb_base_ram_ctrl.sv
// Scoreboard bench for base_ram_ctrl: behavioural SRAM, expected acks queued at request time
// and popped by a negedge monitor that checks port, latency and read data.
module tb_base_ram_ctrl;
    import base_ram_ctrl_pkg::*;

    localparam int ADDR_W = 20;
    localparam int WAIT   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_ce_i, mem_ce_i, mem_we_i;
    logic [31:0]       if_addr_i, mem_addr_i, mem_data_i;
    logic [3:0]        mem_sel_i;
    logic [31:0]       if_data_o, mem_data_o, ram_data_i, ram_data_o;
    logic              if_ack_o, mem_ack_o, stall_o, ram_data_oe;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [3:0]        ram_be_n_o;
    logic              ram_ce_n_o, ram_oe_n_o, ram_we_n_o;

    base_ram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_ack_o(mem_ack_o),
        .stall_o(stall_o),
        .ram_data_i(ram_data_i), .ram_data_o(ram_data_o), .ram_data_oe(ram_data_oe),
        .ram_addr_o(ram_addr_o), .ram_be_n_o(ram_be_n_o),
        .ram_ce_n_o(ram_ce_n_o), .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural asynchronous SRAM.
    logic [31:0] sram [0:255];
    assign ram_data_i = (!ram_ce_n_o && !ram_oe_n_o) ? sram[ram_addr_o[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (!ram_ce_n_o && !ram_we_n_o && ram_data_oe)
            for (int b = 0; b < 4; b++)
                if (!ram_be_n_o[b]) sram[ram_addr_o[7:0]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] data;
        int          cycle;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (if_ack_o || mem_ack_o) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_ack", {62'd0, if_ack_o, mem_ack_o}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("ack_port", {62'd0, if_ack_o, mem_ack_o}, e.is_mem ? 64'd1 : 64'd2);
                check_eq("ack_cycle", 64'(cyc), 64'(e.cycle));
                if (!e.we)
                    check_eq(e.is_mem ? "mem_rdata" : "if_rdata",
                             64'(e.is_mem ? mem_data_o : if_data_o), 64'(e.data));
            end
        end
    end

    task automatic bus_op(input bit is_mem, input bit we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] exp_rd,
                          output logic [ADDR_W-1:0] obs_addr, output logic [3:0] obs_be_n,
                          output int we_low, output logic oe_at_ack);
        int  base;
        bit  got;
        exp_t e;
        @(negedge clk);
        if (is_mem) begin
            mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wdata;
        end else begin
            if_ce_i = 1'b1; if_addr_i = addr;
        end
        base = cyc;
        e.is_mem = is_mem; e.we = we; e.data = exp_rd; e.cycle = base + 1 + WAIT + (we ? 1 : 0);
        exp_q.push_back(e);
        @(negedge clk);
        obs_addr  = ram_addr_o;
        obs_be_n  = ram_be_n_o;
        we_low    = 0;
        oe_at_ack = 1'b0;
        got       = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (!ram_we_n_o) we_low++;
            if (is_mem ? mem_ack_o : if_ack_o) begin
                got       = 1'b1;
                oe_at_ack = ram_data_oe;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("ack_seen", {63'd0, got}, 64'd1);
        if (is_mem) mem_ce_i = 1'b0; else if_ce_i = 1'b0;
    endtask

    logic [ADDR_W-1:0] o_addr;
    logic [3:0]        o_be;
    int                o_we;
    logic              o_oe;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, acks, if_ack_cyc;
        bit got;
        exp_t e;

        for (int i = 0; i < 256; i++) sram[i] = 32'h1000_0000 + i;
        sram[0] = 32'h0123_4567;
        sram[1] = 32'hCAFE_F00D;
        sram[2] = 32'hAAAA_BBBB;
        sram[4] = 32'hDEAD_BEEF;

        // 1: reset values and stall behaviour
        rst_n = 1'b0;
        if_ce_i = 1'b1; if_addr_i = '0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ce_n", {63'd0, ram_ce_n_o}, 64'd1);
        check_eq("rst_oe_n", {63'd0, ram_oe_n_o}, 64'd1);
        check_eq("rst_we_n", {63'd0, ram_we_n_o}, 64'd1);
        check_eq("rst_be_n", {60'd0, ram_be_n_o}, 64'hF);
        check_eq("rst_data_oe", {63'd0, ram_data_oe}, 64'd0);
        check_eq("rst_addr", 64'(ram_addr_o), 64'd0);
        check_eq("rst_acks", {62'd0, if_ack_o, mem_ack_o}, 64'd0);
        check_eq("rst_rdata", {if_data_o, mem_data_o}, 64'd0);
        check_eq("rst_stall_if", {63'd0, stall_o}, 64'd1);
        if_ce_i = 1'b0; mem_ce_i = 1'b1; #1;
        check_eq("rst_stall_mem", {63'd0, stall_o}, 64'd1);
        mem_ce_i = 1'b0; #1;
        check_eq("rst_stall_none", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2: fetch 0x10
        bus_op(1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, o_addr, o_be, o_we, o_oe);
        check_eq("fetch_addr", 64'(o_addr), 64'd4);
        check_eq("fetch_be_n", 64'(o_be), 64'h0);

        // 3: partial write, then read back through the data port
        bus_op(1'b1, 1'b1, 32'h0000_0008, 4'b0011, 32'h1234_5678, 32'h0, o_addr, o_be, o_we, o_oe);
        check_eq("wr_addr", 64'(o_addr), 64'd2);
        check_eq("wr_be_n", 64'(o_be), 64'hC);
        check_eq("wr_we_low_cycles", 64'(o_we), 64'(WAIT));
        check_eq("wr_oe_in_done", {63'd0, o_oe}, 64'd1);
        @(negedge clk);
        check_eq("wr_sram_word", 64'(sram[2]), 64'hAAAA_5678);
        check_eq("idle_data_oe", {63'd0, ram_data_oe}, 64'd0);
        bus_op(1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 32'hAAAA_5678, o_addr, o_be, o_we, o_oe);
        check_eq("rd_be_n", 64'(o_be), 64'h0);

        // sel = 0 write still completes, touches no lane
        bus_op(1'b1, 1'b1, 32'h0000_0004, 4'h0, 32'hFFFF_FFFF, 32'h0, o_addr, o_be, o_we, o_oe);
        check_eq("sel0_be_n", 64'(o_be), 64'hF);
        @(negedge clk);
        check_eq("sel0_sram_word", 64'(sram[1]), 64'hCAFE_F00D);

        // address aliasing above ADDR_W+1
        bus_op(1'b0, 1'b0, 32'hFFC0_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, o_addr, o_be, o_we, o_oe);
        check_eq("alias_addr", 64'(o_addr), 64'd4);

        // 4: simultaneous fetch and data read; data port wins
        @(negedge clk);
        if_ce_i = 1'b1; if_addr_i = 32'h0;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h4; mem_sel_i = 4'hF;
        base = cyc;
        e.is_mem = 1'b1; e.we = 1'b0; e.data = 32'hCAFE_F00D; e.cycle = base + 1 + WAIT;
        exp_q.push_back(e);
        if_ack_cyc = base + 3 + 2 * WAIT;
        e.is_mem = 1'b0; e.we = 1'b0; e.data = 32'h0123_4567; e.cycle = if_ack_cyc;
        exp_q.push_back(e);
        #1;
        check_eq("dual_stall_start", {63'd0, stall_o}, 64'd1);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            check_eq("dual_stall", {63'd0, stall_o}, (cyc == if_ack_cyc) ? 64'd0 : 64'd1);
            if (mem_ack_o) mem_ce_i = 1'b0;
            if (if_ack_o) begin
                if_ce_i = 1'b0;
                got = 1'b1;
            end
        end
        check_eq("dual_if_ack_seen", {63'd0, got}, 64'd1);
        #1;
        check_eq("dual_stall_end", {63'd0, stall_o}, 64'd0);
        repeat (2) @(negedge clk);

        // 5: async reset during WR discards the write
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0030; mem_sel_i = 4'hF;
        mem_data_i = 32'h5555_AAAA;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (!ram_we_n_o) got = 1'b1;
        end
        check_eq("wr_started", {63'd0, got}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_we_n", {63'd0, ram_we_n_o}, 64'd1);
        check_eq("arst_ce_n", {63'd0, ram_ce_n_o}, 64'd1);
        check_eq("arst_data_oe", {63'd0, ram_data_oe}, 64'd0);
        check_eq("arst_acks", {62'd0, if_ack_o, mem_ack_o}, 64'd0);
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_state_idle", 64'(dut.r_state), 64'(S_IDLE));
        check_eq("arst_no_ack", {62'd0, if_ack_o, mem_ack_o}, 64'd0);
        check_eq("arst_sram_untouched", 64'(sram[12]), 64'h1000_000C);
        bus_op(1'b0, 1'b0, 32'h0000_0004, 4'h0, 32'h0, 32'hCAFE_F00D, o_addr, o_be, o_we, o_oe);

        // 6: fetch request held continuously
        @(negedge clk);
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            e.is_mem = 1'b0; e.we = 1'b0; e.data = 32'hDEAD_BEEF;
            e.cycle = base + 1 + WAIT + k * (WAIT + 2);
            exp_q.push_back(e);
        end
        acks = 0;
        for (int i = 0; i < 60 && acks < 4; i++) begin
            @(negedge clk);
            if (if_ack_o) acks++;
        end
        if_ce_i = 1'b0;
        check_eq("stream_ack_count", 64'(acks), 64'd4);
        repeat (8) @(negedge clk);
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
